// File: rtl/seven_seg_serial_sender_pkg.sv
// Shared constants and types for the serial 7-segment link: segment glyphs,
// frame geometry and the sender state encoding.
package seven_seg_pkg;

    localparam int FRAME_BITS  = 10;
    localparam int DIGIT_COUNT = 4;
    localparam int BUFFER_BITS = FRAME_BITS * DIGIT_COUNT;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h21;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h73;
    localparam logic [7:0] SEG_4     = 8'h65;
    localparam logic [7:0] SEG_5     = 8'h76;
    localparam logic [7:0] SEG_6     = 8'h7E;
    localparam logic [7:0] SEG_7     = 8'h23;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h77;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_LOW,
        BIT_HIGH,
        GAP
    } senderState_t;

    // A frame is the digit address followed by its segment byte, sent MSB first.
    function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [1:0] address,
                                                         input logic [7:0] segments);
        return {address, segments};
    endfunction

endpackage

// File: rtl/seven_seg_serial_sender_if.sv
// Request/handshake and two-wire link signals of the serial 7-segment sender.
interface seven_seg_serial_sender_if;
    import seven_seg_pkg::*;

    logic                       startRequest;
    logic                       ready;
    logic [4*DIGIT_COUNT-1:0]   digitValues;
    logic [DIGIT_COUNT-1:0]     dotEnables;
    logic                       doneStrobe;
    logic                       serialClockOut;
    logic                       serialDataOut;

    modport master (
        output startRequest, digitValues, dotEnables,
        input  ready, doneStrobe, serialClockOut, serialDataOut
    );

    modport slave (
        input  startRequest, digitValues, dotEnables,
        output ready, doneStrobe, serialClockOut, serialDataOut
    );

endinterface

// File: rtl/hex_to_segment.sv
// Combinational digit-value to segment-byte encoder; 10 shows a minus sign,
// 11..15 are blank, and the dot flag adds the decimal point.
module hex_to_segment
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dot,
    output logic [7:0] segments
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        case (value)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            4'd10:   glyph = SEG_MINUS;
            default: glyph = SEG_BLANK;
        endcase
        segments = dot ? (glyph | SEG_DP) : glyph;
    end

endmodule

// File: rtl/seven_seg_serial_sender.sv
// Sends four 10-bit address+segment frames over a clock/data link per request,
// with full-period bit cells and an idle gap between frames.
module seven_seg_serial_sender
    import seven_seg_pkg::*;
#(
    parameter int CLOCK_DIV  = 12,
    parameter int GAP_CYCLES = 24
) (
    input  logic                       clock,
    input  logic                       resetN,
    seven_seg_serial_sender_if.slave   bus
);

    localparam int COUNT_MAX = (GAP_CYCLES > CLOCK_DIV) ? GAP_CYCLES : CLOCK_DIV;
    localparam int COUNT_W   = $clog2(COUNT_MAX + 1);

    localparam logic [COUNT_W-1:0] HALF_LAST  = COUNT_W'(CLOCK_DIV - 1);
    localparam logic [COUNT_W-1:0] GAP_LAST   = COUNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         LAST_BIT   = 4'(FRAME_BITS - 1);
    localparam logic [1:0]         LAST_FRAME = 2'(DIGIT_COUNT - 1);

    senderState_t               state, stateNext;
    logic [COUNT_W-1:0]         cycleCount, cycleCountNext;
    logic [3:0]                 bitIndex, bitIndexNext;
    logic [1:0]                 frameIndex, frameIndexNext;
    logic [BUFFER_BITS-1:0]     shiftBuffer, shiftBufferNext;
    logic [4*DIGIT_COUNT-1:0]   digitLatch, digitLatchNext;
    logic [DIGIT_COUNT-1:0]     dotLatch, dotLatchNext;
    logic                       readyNext, doneNext, serialClockNext, serialDataNext;
    logic [BUFFER_BITS-1:0]     loadImage;

    // Frame 0 sits in the top bits so the buffer always shifts out of its MSB.
    for (genvar k = 0; k < DIGIT_COUNT; k++) begin : g_digit
        logic [7:0] segments;

        hex_to_segment u_hex (
            .value    (digitLatch[4*k +: 4]),
            .dot      (dotLatch[k]),
            .segments (segments)
        );

        assign loadImage[BUFFER_BITS-1-FRAME_BITS*k -: FRAME_BITS] = buildFrame(2'(k), segments);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            cycleCount         <= '0;
            bitIndex           <= '0;
            frameIndex         <= '0;
            shiftBuffer        <= '0;
            digitLatch         <= '0;
            dotLatch           <= '0;
            bus.ready          <= 1'b1;
            bus.doneStrobe     <= 1'b0;
            bus.serialClockOut <= 1'b0;
            bus.serialDataOut  <= 1'b0;
        end else begin
            state              <= stateNext;
            cycleCount         <= cycleCountNext;
            bitIndex           <= bitIndexNext;
            frameIndex         <= frameIndexNext;
            shiftBuffer        <= shiftBufferNext;
            digitLatch         <= digitLatchNext;
            dotLatch           <= dotLatchNext;
            bus.ready          <= readyNext;
            bus.doneStrobe     <= doneNext;
            bus.serialClockOut <= serialClockNext;
            bus.serialDataOut  <= serialDataNext;
        end
    end

    always_comb begin
        stateNext       = state;
        cycleCountNext  = cycleCount;
        bitIndexNext    = bitIndex;
        frameIndexNext  = frameIndex;
        shiftBufferNext = shiftBuffer;
        digitLatchNext  = digitLatch;
        dotLatchNext    = dotLatch;
        doneNext        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.startRequest && bus.ready) begin
                    digitLatchNext = bus.digitValues;
                    dotLatchNext   = bus.dotEnables;
                    stateNext      = LOAD;
                end
            end

            LOAD: begin
                shiftBufferNext = loadImage;
                frameIndexNext  = '0;
                bitIndexNext    = LAST_BIT;
                cycleCountNext  = '0;
                stateNext       = BIT_LOW;
            end

            BIT_LOW: begin
                if (cycleCount == HALF_LAST) begin
                    cycleCountNext = '0;
                    stateNext      = BIT_HIGH;
                end else begin
                    cycleCountNext = cycleCount + 1'b1;
                end
            end

            BIT_HIGH: begin
                if (cycleCount == HALF_LAST) begin
                    cycleCountNext  = '0;
                    shiftBufferNext = {shiftBuffer[BUFFER_BITS-2:0], 1'b0};
                    if (bitIndex == 4'd0) begin
                        stateNext = GAP;
                    end else begin
                        bitIndexNext = bitIndex - 1'b1;
                        stateNext    = BIT_LOW;
                    end
                end else begin
                    cycleCountNext = cycleCount + 1'b1;
                end
            end

            GAP: begin
                if (cycleCount == GAP_LAST) begin
                    cycleCountNext = '0;
                    if (frameIndex == LAST_FRAME) begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        frameIndexNext = frameIndex + 1'b1;
                        bitIndexNext   = LAST_BIT;
                        stateNext      = BIT_LOW;
                    end
                end else begin
                    cycleCountNext = cycleCount + 1'b1;
                end
            end

            default: stateNext = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with it.
        readyNext       = (stateNext == IDLE);
        serialClockNext = (stateNext == BIT_HIGH);
        serialDataNext  = ((stateNext == BIT_LOW) || (stateNext == BIT_HIGH))
                          && shiftBufferNext[BUFFER_BITS-1];
    end

endmodule

// File: tb/tb_seven_seg_serial_sender.sv
// Randomized bench for the serial 7-segment sender with a link-level receiver model.
module tb_seven_seg_serial_sender;

    localparam int CLOCK_DIV  = 2;
    localparam int GAP_CYCLES = 4;
    localparam int LATENCY    = 1 + 4 * (20 * CLOCK_DIV + GAP_CYCLES);
    localparam int BOUND      = LATENCY + 60;

    logic clock  = 1'b0;
    logic resetN = 1'b1;

    seven_seg_serial_sender_if bus();

    seven_seg_serial_sender #(
        .CLOCK_DIV  (CLOCK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] segTable [16];

    // Receiver model: shifts data in on each rising link clock, emits a frame every 10 bits.
    logic [9:0] rxFrames[$];
    logic [9:0] rxShift   = '0;
    int         rxBits    = 0;
    logic       prevSck   = 1'b0;
    int         lowRun    = 0;
    int         badFrames = 0;

    always @(negedge clock) begin
        if (!resetN) begin
            rxShift = '0;
            rxBits  = 0;
            prevSck = 1'b0;
            lowRun  = 0;
        end else begin
            if (bus.serialClockOut && !prevSck) begin
                rxShift = {rxShift[8:0], bus.serialDataOut};
                rxBits++;
                if (rxBits == 10) begin
                    rxFrames.push_back(rxShift);
                    rxBits = 0;
                end
            end
            lowRun = bus.serialClockOut ? 0 : lowRun + 1;
            if (lowRun == CLOCK_DIV + 1 && rxBits != 0) badFrames++;
            prevSck = bus.serialClockOut;
        end
    end

    function automatic logic [9:0] expFrame(input int k, input logic [15:0] dv, input logic [3:0] de);
        logic [7:0] s;
        s = segTable[dv[4*k +: 4]];
        if (de[k]) s = s | 8'h80;
        return {k[1:0], s};
    endfunction

    task automatic waitReady(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (n >= BOUND) begin
            testsRun++;
            testsFailed++;
            $display("FAIL %s wait_ready: ready=%b required 1 within %0d cycles", name, bus.ready, BOUND);
        end
    endtask

    task automatic sendUpdate(input logic [15:0] dv, input logic [3:0] de, input bit interfere,
                              input string name);
        int base    = rxFrames.size();
        int badBase = badFrames;
        int lat     = 0;
        int extra   = 0;
        int busy    = 0;
        bit pulsed  = 1'b0;
        @(negedge clock);
        waitReady(name);
        bus.startRequest = 1'b1;
        bus.digitValues  = dv;
        bus.dotEnables   = de;
        @(negedge clock);
        bus.startRequest = 1'b0;
        bus.digitValues  = 16'($urandom);
        bus.dotEnables   = 4'($urandom);
        testsRun++;
        if (bus.ready !== 1'b0) begin
            testsFailed++;
            $display("FAIL %s accept_ready: got %b required 0", name, bus.ready);
        end
        while (bus.doneStrobe !== 1'b1 && lat < BOUND) begin
            @(negedge clock);
            lat++;
            if (pulsed && bus.startRequest) begin
                bus.startRequest = 1'b0;
            end else if (interfere && !pulsed && rxFrames.size() - base == 1 && rxBits == 5) begin
                bus.startRequest = 1'b1;
                bus.digitValues  = 16'($urandom);
                pulsed = 1'b1;
            end
        end
        testsRun++;
        if (lat != LATENCY) begin
            testsFailed++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, lat, LATENCY);
        end
        if (interfere) begin
            testsRun++;
            if (!pulsed) begin
                testsFailed++;
                $display("FAIL %s mid_pulse: busy request issued=%0d required 1", name, pulsed);
            end
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.doneStrobe) extra++;
            if (!bus.ready) busy++;
        end
        testsRun++;
        if (extra != 0 || busy != 0) begin
            testsFailed++;
            $display("FAIL %s after_done: extra doneStrobe=%0d busy cycles=%0d required 0/0", name, extra, busy);
        end
        testsRun++;
        if (rxFrames.size() - base != 4) begin
            testsFailed++;
            $display("FAIL %s frame_count: got %0d required 4", name, rxFrames.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                testsRun++;
                if (rxFrames[base + k] !== expFrame(k, dv, de)) begin
                    testsFailed++;
                    $display("FAIL %s frame%0d: got %b required %b", name, k, rxFrames[base + k], expFrame(k, dv, de));
                end
            end
        end
        testsRun++;
        if (badFrames != badBase) begin
            testsFailed++;
            $display("FAIL %s edge_count: partial frames=%0d required 0", name, badFrames - badBase);
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        bus.startRequest = 1'b0;
        bus.digitValues  = '0;
        bus.dotEnables   = '0;
        #2 resetN = 1'b0;
        #1;
        testsRun++;
        if ({bus.ready, bus.doneStrobe, bus.serialClockOut, bus.serialDataOut} !== 4'b1000) begin
            testsFailed++;
            $display("FAIL reset_outputs: rdy/done/sck/sd=%b required 1000",
                     {bus.ready, bus.doneStrobe, bus.serialClockOut, bus.serialDataOut});
        end
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if ({bus.ready, bus.doneStrobe, bus.serialClockOut, bus.serialDataOut} !== 4'b1000) bad++;
        end
        testsRun++;
        if (bad != 0) begin
            testsFailed++;
            $display("FAIL idle_outputs: bad cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_basic;
        logic [9:0] want [4];
        int base = rxFrames.size();
        want = '{10'b00_0110_0101, 10'b01_0111_0011, 10'b10_0101_1011, 10'b11_0010_0001};
        sendUpdate(16'h1234, 4'b0000, 1'b0, "basic");
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if (rxFrames.size() <= base + k || rxFrames[base + k] !== want[k]) begin
                testsFailed++;
                $display("FAIL basic_literal%0d: got %b required %b", k,
                         (rxFrames.size() > base + k) ? rxFrames[base + k] : 10'bx, want[k]);
            end
        end
    endtask

    task automatic test_dots;
        logic [7:0] want [4];
        int base = rxFrames.size();
        want = '{8'hBF, 8'h77, 8'hC0, 8'h00};
        sendUpdate(16'hFA90, 4'b0101, 1'b0, "dots");
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if (rxFrames.size() <= base + k || rxFrames[base + k][7:0] !== want[k]) begin
                testsFailed++;
                $display("FAIL dots_byte%0d: got %h required %h", k,
                         (rxFrames.size() > base + k) ? rxFrames[base + k][7:0] : 8'hxx, want[k]);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) sendUpdate(16'($urandom), 4'($urandom), 1'b0, "random");
    endtask

    task automatic test_busy_request;
        sendUpdate(16'($urandom), 4'($urandom), 1'b1, "busy");
    endtask

    task automatic test_back_to_back;
        logic [15:0] dv = 16'($urandom);
        logic [3:0]  de = 4'($urandom);
        int base    = rxFrames.size();
        int badBase = badFrames;
        int lat     = 0;
        @(negedge clock);
        waitReady("b2b");
        bus.startRequest = 1'b1;
        bus.digitValues  = dv;
        bus.dotEnables   = de;
        @(negedge clock);
        while (bus.doneStrobe !== 1'b1 && lat < BOUND) begin
            @(negedge clock);
            lat++;
        end
        testsRun++;
        if (lat != LATENCY) begin
            testsFailed++;
            $display("FAIL b2b_first_latency: got %0d required %0d", lat, LATENCY);
        end
        @(negedge clock);
        testsRun++;
        if (bus.ready !== 1'b0) begin
            testsFailed++;
            $display("FAIL b2b_restart: ready=%b required 0 one cycle after doneStrobe", bus.ready);
        end
        lat = 1;
        while (bus.doneStrobe !== 1'b1 && lat < BOUND) begin
            @(negedge clock);
            lat++;
        end
        bus.startRequest = 1'b0;
        testsRun++;
        if (lat != LATENCY + 1) begin
            testsFailed++;
            $display("FAIL b2b_period: got %0d required %0d", lat, LATENCY + 1);
        end
        repeat (30) @(negedge clock);
        testsRun++;
        if (rxFrames.size() - base != 8) begin
            testsFailed++;
            $display("FAIL b2b_frame_count: got %0d required 8", rxFrames.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                testsRun++;
                if (rxFrames[base + k] !== expFrame(k % 4, dv, de)) begin
                    testsFailed++;
                    $display("FAIL b2b_frame%0d: got %b required %b", k, rxFrames[base + k], expFrame(k % 4, dv, de));
                end
            end
        end
        testsRun++;
        if (badFrames != badBase || bus.ready !== 1'b1) begin
            testsFailed++;
            $display("FAIL b2b_end: partial frames=%0d ready=%b required 0/1", badFrames - badBase, bus.ready);
        end
    endtask

    task automatic test_midframe_reset;
        int base = rxFrames.size();
        int n    = 0;
        @(negedge clock);
        waitReady("mid_reset");
        bus.startRequest = 1'b1;
        bus.digitValues  = 16'($urandom);
        bus.dotEnables   = 4'($urandom);
        @(negedge clock);
        bus.startRequest = 1'b0;
        while (!(rxFrames.size() - base == 2 && bus.serialClockOut === 1'b1) && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        testsRun++;
        if (n >= BOUND) begin
            testsFailed++;
            $display("FAIL mid_reset_reach: frame 2 high phase not seen within %0d cycles", BOUND);
        end
        #2 resetN = 1'b0;
        #1;
        testsRun++;
        if ({bus.ready, bus.doneStrobe, bus.serialClockOut, bus.serialDataOut} !== 4'b1000) begin
            testsFailed++;
            $display("FAIL mid_reset_async: rdy/done/sck/sd=%b required 1000",
                     {bus.ready, bus.doneStrobe, bus.serialClockOut, bus.serialDataOut});
        end
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        testsRun++;
        if (bus.ready !== 1'b1 || bus.serialClockOut !== 1'b0) begin
            testsFailed++;
            $display("FAIL mid_reset_release: ready=%b sck=%b required 1/0", bus.ready, bus.serialClockOut);
        end
        sendUpdate(16'($urandom), 4'($urandom), 1'b0, "after_reset");
    endtask

    initial begin
        segTable = '{8'h3F, 8'h21, 8'h5B, 8'h73, 8'h65, 8'h76, 8'h7E, 8'h23,
                     8'h7F, 8'h77, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_basic();
        test_dots();
        test_random();
        test_busy_request();
        test_back_to_back();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
